// File: rtl/mult8_dot_accumulator_if.sv
// Beat/result bus between the 8x8 multiplier array, the dot-product
// accumulator and the result consumer.
// slave  : the accumulator (takes product beats, drives frame results)
// master : the environment (drives product beats, consumes frame results)
interface mult8_dot_accumulator_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;
  logic             out_trunc;

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf, out_trunc
  );

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf, out_trunc
  );
endinterface

// File: rtl/mult8_dot_accumulator.sv
// Dot-product accumulator behind the 8x8 unsigned multiplier.
// Sums a frame of 16-bit products (closed by in_last or by MAX_LEN beats)
// and holds the result on a valid/ready port until it is taken.
// Optional build macro MULT8_ACC_SATURATE_EN: the add saturates at all ones
// instead of wrapping modulo 2^ACC_W; overflow is flagged in both builds.
module mult8_dot_accumulator #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 255
) (
  input logic                    clk,
  input logic                    rst,
  mult8_dot_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [7:0]       count, count_nx;
  logic             ovf, ovf_nx;

  logic [ACC_W-1:0] out_sum_r;
  logic [7:0]       out_count_r;
  logic             out_ovf_r, out_trunc_r;
  logic             load_out;

  logic             accept;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_w;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [7:0]       cnt_inc;
  logic             ovf_inc;
  logic             at_max;
  logic             closing;

  assign bus.in_ready  = !rst && (state != HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = out_sum_r;
  assign bus.out_count = out_count_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_trunc = out_trunc_r;

  // Datapath for the accepted beat: a fresh frame starts from zero, so the
  // IDLE load and the ACCUM add share one adder.
  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    sum_w    = {1'b0, acc_base} + (ACC_W + 1)'(bus.in_p);
    carry    = sum_w[ACC_W];
`ifdef MULT8_ACC_SATURATE_EN
    acc_add  = carry ? '1 : sum_w[ACC_W-1:0];
`else
    acc_add  = sum_w[ACC_W-1:0];
`endif
    cnt_inc  = ((state == ACCUM) ? count : 8'd0) + 8'd1;
    ovf_inc  = ((state == ACCUM) ? ovf : 1'b0) | carry;
    at_max   = (cnt_inc == 8'(MAX_LEN));
    closing  = bus.in_last || at_max;
  end

  // Next-state and accumulator update.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    ovf_nx   = ovf;
    load_out = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nx   = acc_add;
          count_nx = cnt_inc;
          ovf_nx   = ovf_inc;
          if (closing) begin
            state_nx = HOLD;
            load_out = 1'b1;
          end else begin
            state_nx = ACCUM;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, accumulator and result registers; results persist after HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      out_sum_r   <= '0;
      out_count_r <= '0;
      out_ovf_r   <= 1'b0;
      out_trunc_r <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
      if (load_out) begin
        out_sum_r   <= acc_add;
        out_count_r <= cnt_inc;
        out_ovf_r   <= ovf_inc;
        out_trunc_r <= at_max && !bus.in_last;
      end
    end
  end

endmodule

// File: tb/tb_mult8_dot_accumulator.sv
// Bench for mult8_dot_accumulator (ACC_W=16, MAX_LEN=4 to reach overflow and
// truncation quickly). A frame-level model (queue of accepted products,
// summed when the frame closes) is compared with the DUT every cycle.
module tb_mult8_dot_accumulator;
  localparam int     ACC_W   = 16;
  localparam int     MAX_LEN = 4;
  localparam longint MAXV    = (longint'(1) << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult8_dot_accumulator_if #(.ACC_W(ACC_W)) bus ();

  mult8_dot_accumulator #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model
  bit     m_hold  = 1'b0;
  longint m_q[$];
  longint m_sum   = 0;
  int     m_cnt   = 0;
  bit     m_ovf   = 1'b0;
  bit     m_trunc = 1'b0;

  initial begin
    longint t;
    forever begin
      @(negedge clk);
      chk("in_ready",  64'(bus.in_ready),  64'(!rst && !m_hold));
      chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
      chk("out_sum",   64'(bus.out_sum),   64'(m_sum));
      chk("out_count", 64'(bus.out_count), 64'(m_cnt));
      chk("out_ovf",   64'(bus.out_ovf),   64'(m_ovf));
      chk("out_trunc", 64'(bus.out_trunc), 64'(m_trunc));
      if (rst) begin
        m_hold = 0; m_q.delete();
        m_sum = 0; m_cnt = 0; m_ovf = 0; m_trunc = 0;
      end else if (m_hold) begin
        if (bus.out_ready) m_hold = 0;
      end else if (bus.in_valid) begin
        m_q.push_back(longint'(bus.in_p));
        if (bus.in_last || m_q.size() == MAX_LEN) begin
          t = 0;
          foreach (m_q[i]) t += m_q[i];
          m_cnt = m_q.size();
          m_ovf = (t > MAXV);
`ifdef MULT8_ACC_SATURATE_EN
          m_sum = (t > MAXV) ? MAXV : t;
`else
          m_sum = t & MAXV;
`endif
          m_trunc = !bus.in_last;
          m_hold  = 1;
          m_q.delete();
        end
      end
    end
  end

  // Present one beat and hold it until accepted; waits = cycles stalled.
  task automatic beat(input int p, input bit last, output int waits);
    bus.in_valid = 1'b1;
    bus.in_p     = 16'(p);
    bus.in_last  = last;
    waits = 0;
    while (!bus.in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 50) chk("beat_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result and pin DUT and model to literal values.
  task automatic expect_result(input string tag, input longint s, input int c,
                               input bit o, input bit tr);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sum"},   64'(bus.out_sum),   64'(s));
    chk({tag, "_count"}, 64'(bus.out_count), 64'(c));
    chk({tag, "_ovf"},   64'(bus.out_ovf),   64'(o));
    chk({tag, "_trunc"}, 64'(bus.out_trunc), 64'(tr));
    chk({tag, "_model"}, 64'(m_sum),         64'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;

    // single-beat frame
    bus.out_ready = 1'b1;
    beat(65025, 1'b1, w);
    expect_result("single", 65025, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("single_idle_ready", 64'(bus.in_ready), 64'd1);

    // three beats with a gap, consumer stalls 4 cycles
    bus.out_ready = 1'b0;
    beat(100, 1'b0, w);
    @(posedge clk); #1;
    beat(200, 1'b0, w);
    beat(300, 1'b1, w);
    expect_result("three", 600, 3, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(bus.in_ready),  64'd0);
      chk("stall_valid",    64'(bus.out_valid), 64'd1);
      chk("stall_sum",      64'(bus.out_sum),   64'd600);
    end
    bus.out_ready = 1'b1;

    // overflow
    beat(65025, 1'b0, w);
    beat(65025, 1'b1, w);
`ifdef MULT8_ACC_SATURATE_EN
    expect_result("ovf", 65535, 2, 1'b1, 1'b0);
`else
    expect_result("ovf", 64514, 2, 1'b1, 1'b0);
`endif

    // truncation at MAX_LEN, then the remainder as its own frame
    for (int i = 0; i < 4; i++) beat(1, 1'b0, w);
    expect_result("trunc", 4, 4, 1'b0, 1'b1);
    beat(1, 1'b0, w);
    chk("trunc_bubble", 64'(w), 64'd1);
    beat(1, 1'b1, w);
    expect_result("rest", 2, 2, 1'b0, 1'b0);

    // reset mid-frame
    beat(500, 1'b0, w);
    beat(600, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    beat(7, 1'b1, w);
    expect_result("rstmid", 7, 1, 1'b0, 1'b0);

    // back-to-back frames, one bubble each
    @(posedge clk); #1;
    beat(1, 1'b1, w);
    expect_result("b2b1", 1, 1, 1'b0, 1'b0);
    beat(2, 1'b1, w);
    chk("b2b_bubble", 64'(w), 64'd1);
    expect_result("b2b2", 2, 1, 1'b0, 1'b0);

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_p      = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(60000, 65025))
                                                   : 16'($urandom_range(0, 65025));
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult8_dot_accumulator.md
Name: mult8_dot_accumulator

Overview:
- Downstream consumer of the 8x8 unsigned multiplier's 16-bit product P.
- Accumulates a frame of products into a dot-product sum.
- Frames are delimited by a last flag; each finished sum is presented on a valid/ready output port.
- Sole sequential stage between the combinational multiplier array and the result bus.

Parameters:
ACC_W, 24, accumulator/result width in bits (min 16)
MAX_LEN, 255, max products per frame before forced termination (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
in_p  input  16  unsigned product from multiplier (P)
in_last  input  1  beat is final term of current frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_sum  output  ACC_W  accumulated sum of frame
out_count  output  8  number of products in frame
out_ovf  output  1  sum exceeded 2^ACC_W-1 during frame
out_trunc  output  1  frame closed by MAX_LEN, not in_last

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, acc=0, count=0, ovf=0, trunc=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_trunc=0. in_ready=0 while rst is high.
- Reset mid-frame or mid-HOLD discards all partial or pending results.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open.
  - HOLD: result pending.
- in_ready = !rst && (state != HOLD).
- Accept = in_valid && in_ready.
- In IDLE, accept: acc=in_p (zero-extended), count=1, ovf=0. Goes to ACCUM, or to HOLD if closing.
- In ACCUM, accept: acc=acc+in_p, count=count+1. ovf |= carry out of bit ACC_W-1.
- Wrap: the sum wraps modulo 2^ACC_W (default build).
- Closing beat: an accepted beat with in_last=1, or the beat that makes count==MAX_LEN.
  - trunc=1 when count==MAX_LEN and in_last=0.
- Latency: closing beat accepted at cycle N gives out_valid=1 at N+1.
  - out_sum, out_count, out_ovf and out_trunc are registered copies, stable throughout HOLD.
- HOLD: in_ready=0; out_valid stays high until out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid=0 at the next edge, in_ready=1 that same cycle.
- No beat accepted in the HOLD-exit cycle (back-to-back throughput is one bubble per frame).
- Without a beat, state and acc hold; in_valid gaps inside a frame are legal.
- out_ready while out_valid=0: ignored.
- in_p, in_last: ignored when not accepted.
- MAX_LEN=1: every beat is a closing beat; out_trunc=0 only if in_last=1.
- Outputs are not cleared on leaving HOLD; they keep the last values until the next frame closes.

Optional Feature:
- Macro: MULT8_ACC_SATURATE_EN.
- Defined: the add saturates. If the true sum exceeds 2^ACC_W-1, acc=all ones, ovf=1, and acc stays all ones for the rest of the frame.
- Undefined: modulo wrap as above; ovf is still reported.
- Ports and timing are identical in both builds.

Test Plan:
- Single-beat frame: after reset, in_p=65025 (255*255), in_last=1, out_ready=1 -> next cycle out_valid=1, out_sum=65025, out_count=1, out_ovf=0, out_trunc=0; IDLE one cycle later.
- Three-beat frame with a gap: 100, idle cycle, 200, 300 (last) -> out_sum=600, out_count=3; in_ready=0 while out_ready held low 4 cycles; out_valid and out_sum stable throughout.
- Overflow, ACC_W=16: beats 65025, 65025 (last):
  - default build -> out_sum=64514, out_ovf=1.
  - with MULT8_ACC_SATURATE_EN -> out_sum=65535, out_ovf=1.
- Truncation, MAX_LEN=4: 6 beats of 1, in_last never set -> first result out_sum=4, out_count=4, out_trunc=1.
  - After the handshake, the remaining 2 beats are accepted only once in_ready returns.
  - Second frame closes with in_last on beat 2 -> out_sum=2, out_count=2, out_trunc=0.
- Reset mid-frame: accept 500, 600, assert rst one cycle, then beat 7 with last -> out_sum=7, out_count=1; no output from the aborted frame.
- Back-to-back frames with in_valid held high: frame1 = 1 (last), frame2 = 2 (last) -> two results, sums 1 and 2; exactly one in_ready=0 cycle per HOLD.
